branch_resolve_unit: RTL and testbench

- Execute-stage consumer of the branch comparator's BEQ/BLT flags. It also drives BrUn back to the comparator.
- Decides the branch outcome from funct3 and computes branch, JAL and JALR targets.
- Checks the front-end prediction against the outcome. On a mismatch it issues a registered redirect/flush to fetch.
- Owns a small table of 2-bit saturating counters (BHT) that fetch reads for its taken/not-taken prediction.

---
 rtl/cpu_pkg.sv | 35 +++
 rtl/bht_2bit.sv | 43 ++++
 rtl/branch_resolve_unit.sv | 138 +++++++++++++
 tb/tb_branch_resolve_unit.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared core definitions: branch funct3 encodings, datapath width
// and 2-bit branch counter states with their saturating update.
package cpu_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    function automatic logic [1:0] ctr_next(
        input logic [1:0] c,
        input logic       taken
    );
        logic [1:0] n;
        n = c;
        if (taken) begin
            if (c != ST) n = c + 2'd1;
        end else begin
            if (c != SNT) n = c - 2'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/bht_2bit.sv
// Branch history table of 2-bit saturating counters with a
// combinational read port and a synchronous update port.
module bht_2bit
    import cpu_pkg::*;
#(
    parameter int         IDX_W     = 4,
    parameter logic [1:0] CTR_RESET = 2'b01
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_taken,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    localparam int N = 1 << IDX_W;

    logic [1:0] ctr_q [N];
    logic [1:0] ctr_d [N];

    // Read sees the registered value, so a same-cycle update is not forwarded
    assign rd_taken = ctr_q[rd_idx][1];

    always_comb begin
        ctr_d = ctr_q;
        if (wr_en) begin
            ctr_d[wr_idx] = ctr_next(ctr_q[wr_idx], wr_taken);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                ctr_q[i] <= CTR_RESET;
            end
        end else begin
            ctr_q <= ctr_d;
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution: outcome, targets, registered
// redirect/flush on mispredict, BHT training and event counters.
module branch_resolve_unit
    import cpu_pkg::*;
#(
    parameter int         XLEN      = XLEN_DEFAULT,
    parameter int         BHT_IDX_W = 4,
    parameter logic [1:0] CTR_RESET = 2'b01
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    input  logic            ex_is_branch,
    input  logic            ex_is_jal,
    input  logic            ex_is_jalr,
    input  logic [2:0]      ex_funct3,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [XLEN-1:0] ex_rs1,
    input  logic            ex_pred_taken,
    input  logic            BEQ,
    input  logic            BLT,
    output logic            BrUn,
    input  logic [XLEN-1:0] if_pc,
    output logic            if_pred_taken,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush,
    output logic            illegal_br,
    output logic [15:0]     branch_count,
    output logic [15:0]     mispredict_count
);

    logic            redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
    logic            illegal_br_q, illegal_br_d;
    logic [15:0]     branch_count_q, branch_count_d;
    logic [15:0]     mispredict_count_q, mispredict_count_d;

    logic            act;
    logic            sel_jalr, sel_jal, sel_br;
    logic            br_taken, br_illegal;
    logic [XLEN-1:0] br_target, jalr_sum, jalr_target, fall_pc;
    logic            unused_if_pc;

    // Wrong-path instruction sits in EX while our redirect is visible
    assign act = ex_valid & ~redirect_valid_q;

    assign sel_jalr = ex_is_jalr;
    assign sel_jal  = ex_is_jal & ~ex_is_jalr;
    assign sel_br   = ex_is_branch & ~ex_is_jal & ~ex_is_jalr;

    assign BrUn = (ex_funct3 == F3_BLTU) | (ex_funct3 == F3_BGEU);

    always_comb begin
        br_taken   = 1'b0;
        br_illegal = 1'b0;
        case (ex_funct3)
            F3_BEQ:            br_taken = BEQ;
            F3_BNE:            br_taken = ~BEQ;
            F3_BLT, F3_BLTU:   br_taken = BLT & ~BEQ;
            F3_BGE, F3_BGEU:   br_taken = ~BLT;
            default:           br_illegal = 1'b1;
        endcase
    end

    assign br_target   = ex_pc + ex_imm;
    assign jalr_sum    = ex_rs1 + ex_imm;
    assign jalr_target = {jalr_sum[XLEN-1:1], 1'b0};
    assign fall_pc     = ex_pc + XLEN'(4);

    always_comb begin
        redirect_valid_d   = 1'b0;
        redirect_pc_d      = '0;
        illegal_br_d       = 1'b0;
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        unique case (1'b1)
            act & sel_jalr: begin
                redirect_valid_d = 1'b1;
                redirect_pc_d    = jalr_target;
            end
            act & sel_jal: begin
                redirect_valid_d = 1'b1;
                redirect_pc_d    = br_target;
            end
            act & sel_br: begin
                branch_count_d   = branch_count_q + 16'd1;
                illegal_br_d     = br_illegal;
                redirect_valid_d = br_taken != ex_pred_taken;
                redirect_pc_d    = br_taken ? br_target : fall_pc;
            end
            default: ;
        endcase
        if (redirect_valid_d) begin
            mispredict_count_d = mispredict_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_valid_q   <= 1'b0;
            redirect_pc_q      <= '0;
            illegal_br_q       <= 1'b0;
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            redirect_valid_q   <= redirect_valid_d;
            redirect_pc_q      <= redirect_pc_d;
            illegal_br_q       <= illegal_br_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    bht_2bit #(
        .IDX_W    (BHT_IDX_W),
        .CTR_RESET(CTR_RESET)
    ) u_bht (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_idx  (if_pc[BHT_IDX_W+1:2]),
        .rd_taken(if_pred_taken),
        .wr_en   (act & sel_br),
        .wr_idx  (ex_pc[BHT_IDX_W+1:2]),
        .wr_taken(br_taken)
    );

    assign unused_if_pc = ^{if_pc[XLEN-1:BHT_IDX_W+2], if_pc[1:0]};

    assign redirect_valid   = redirect_valid_q;
    assign redirect_pc      = redirect_pc_q;
    assign flush            = redirect_valid_q;
    assign illegal_br       = illegal_br_q;
    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: vector table plus
// scoreboard queue, BHT model, collision and reset corner cases.
module tb_branch_resolve_unit;

    logic        clk;
    logic        rst_n;
    logic        ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_pc, ex_imm, ex_rs1, if_pc;
    logic        ex_pred_taken, BEQ, BLT;
    logic        BrUn, if_pred_taken;
    logic        redirect_valid, flush, illegal_br;
    logic [31:0] redirect_pc;
    logic [15:0] branch_count, mispredict_count;

    branch_resolve_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ex_valid        (ex_valid),
        .ex_is_branch    (ex_is_branch),
        .ex_is_jal       (ex_is_jal),
        .ex_is_jalr      (ex_is_jalr),
        .ex_funct3       (ex_funct3),
        .ex_pc           (ex_pc),
        .ex_imm          (ex_imm),
        .ex_rs1          (ex_rs1),
        .ex_pred_taken   (ex_pred_taken),
        .BEQ             (BEQ),
        .BLT             (BLT),
        .BrUn            (BrUn),
        .if_pc           (if_pc),
        .if_pred_taken   (if_pred_taken),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .flush           (flush),
        .illegal_br      (illegal_br),
        .branch_count    (branch_count),
        .mispredict_count(mispredict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid, br, jal, jalr;
        logic [2:0]  f3;
        logic [31:0] pc, imm, rs1;
        logic        pred, beq, blt;
        logic        e_rv;
        logic [31:0] e_pc;
        logic        e_ill, e_brun, e_tk;
    } vec_t;

    typedef struct {
        logic        rv;
        logic [31:0] pc;
        logic        ill;
    } exp_t;

    exp_t        sb[$];
    vec_t        tbl[19];
    logic [1:0]  bht_m[16];
    logic [15:0] bc_m, mc_m;
    logic        prev_rv;
    int          checks, errors;

    function automatic vec_t mkv(
        logic v, logic b, logic j, logic jr, logic [2:0] f3,
        logic [31:0] pc, logic [31:0] imm, logic [31:0] rs1,
        logic pr, logic beq, logic blt,
        logic erv, logic [31:0] epc, logic eill, logic ebrun, logic etk
    );
        vec_t r;
        r.valid = v; r.br = b; r.jal = j; r.jalr = jr; r.f3 = f3;
        r.pc = pc; r.imm = imm; r.rs1 = rs1;
        r.pred = pr; r.beq = beq; r.blt = blt;
        r.e_rv = erv; r.e_pc = epc; r.e_ill = eill;
        r.e_brun = ebrun; r.e_tk = etk;
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) bht_m[i] = 2'b01;
        bc_m = '0;
        mc_m = '0;
        prev_rv = 1'b0;
        sb.delete();
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard empty got 0 want 1");
            return;
        end
        e = sb.pop_front();
        chk("redirect_valid", 32'(redirect_valid), 32'(e.rv));
        chk("flush", 32'(flush), 32'(e.rv));
        chk("illegal_br", 32'(illegal_br), 32'(e.ill));
        if (e.rv) chk("redirect_pc", redirect_pc, e.pc);
        chk("branch_count", 32'(branch_count), 32'(bc_m));
        chk("mispredict_count", 32'(mispredict_count), 32'(mc_m));
    endtask

    task automatic apply(vec_t v);
        exp_t       e;
        logic [3:0] idx;
        logic       act;
        @(negedge clk);
        ex_valid = v.valid; ex_is_branch = v.br;
        ex_is_jal = v.jal; ex_is_jalr = v.jalr;
        ex_funct3 = v.f3; ex_pc = v.pc; ex_imm = v.imm;
        ex_rs1 = v.rs1; ex_pred_taken = v.pred;
        BEQ = v.beq; BLT = v.blt;
        if_pc = v.pc;
        idx = v.pc[5:2];
        #1;
        chk("BrUn", 32'(BrUn), 32'(v.e_brun));
        chk("if_pred_taken_pre", 32'(if_pred_taken), 32'(bht_m[idx][1]));
        act = v.valid && !prev_rv;
        if (act && v.br && !v.jal && !v.jalr) begin
            bc_m++;
            if (v.e_tk && bht_m[idx] != 2'b11) bht_m[idx]++;
            if (!v.e_tk && bht_m[idx] != 2'b00) bht_m[idx]--;
        end
        if (v.e_rv) mc_m++;
        prev_rv = v.e_rv;
        e.rv = v.e_rv; e.pc = v.e_pc; e.ill = v.e_ill;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic check_bht();
        @(negedge clk);
        ex_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if_pc = 32'(i) << 2;
            #1;
            chk($sformatf("bht_msb[%0d]", i), 32'(if_pred_taken),
                32'(bht_m[i][1]));
        end
    endtask

    initial begin
        vec_t idle;
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        ex_valid = 0; ex_is_branch = 0; ex_is_jal = 0; ex_is_jalr = 0;
        ex_funct3 = '0; ex_pc = '0; ex_imm = '0; ex_rs1 = '0;
        ex_pred_taken = 0; BEQ = 0; BLT = 0; if_pc = '0;
        model_reset();

        idle = mkv(0,0,0,0,3'b000,32'h0,32'h0,32'h0,0,0,0, 0,32'h0,0,0,0);
        tbl[0]  = mkv(1,1,0,0,3'b000,32'h100,32'h20,32'h0,0,1,0, 1,32'h120,0,0,1);
        tbl[1]  = idle;
        tbl[2]  = mkv(1,1,0,0,3'b101,32'h200,32'h40,32'h0,1,0,0, 0,32'h0,0,0,1);
        tbl[3]  = mkv(1,1,0,0,3'b101,32'h200,32'h40,32'h0,1,0,0, 0,32'h0,0,0,1);
        tbl[4]  = mkv(1,1,0,0,3'b001,32'h300,32'h40,32'h0,1,1,0, 1,32'h304,0,0,0);
        tbl[5]  = mkv(1,1,0,0,3'b001,32'h300,32'h40,32'h0,0,0,0, 0,32'h0,0,0,1);
        tbl[6]  = mkv(1,0,0,1,3'b000,32'h400,32'h4,32'h1003,1,0,0, 1,32'h1006,0,0,0);
        tbl[7]  = idle;
        tbl[8]  = mkv(1,1,0,0,3'b110,32'h10,32'h8,32'h0,1,0,1, 0,32'h0,0,1,1);
        tbl[9]  = mkv(1,1,0,0,3'b010,32'h20,32'h100,32'h0,1,1,0, 1,32'h24,1,0,0);
        tbl[10] = idle;
        tbl[11] = mkv(1,0,1,0,3'b000,32'hFFFF_FFF0,32'h20,32'h0,0,0,0, 1,32'h10,0,0,0);
        tbl[12] = idle;
        tbl[13] = mkv(1,1,0,0,3'b100,32'hFFFF_FFFC,32'h8,32'h0,0,1,1, 0,32'h0,0,0,0);
        tbl[14] = mkv(1,1,0,0,3'b110,32'hFFFF_FFFC,32'h8,32'h0,1,0,0, 1,32'h0,0,1,0);
        tbl[15] = idle;
        tbl[16] = mkv(1,1,1,1,3'b000,32'h500,32'h10,32'h2000,0,1,0, 1,32'h2010,0,0,0);
        tbl[17] = idle;
        tbl[18] = mkv(1,1,0,0,3'b111,32'h40,32'h8,32'h0,0,0,1, 0,32'h0,0,1,0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_redirect_valid", 32'(redirect_valid), 32'h0);
        chk("rst_redirect_pc", redirect_pc, 32'h0);
        chk("rst_flush", 32'(flush), 32'h0);
        chk("rst_illegal_br", 32'(illegal_br), 32'h0);
        chk("rst_branch_count", 32'(branch_count), 32'h0);
        chk("rst_mispredict_count", 32'(mispredict_count), 32'h0);
        check_bht();

        for (int i = 0; i < 19; i++) apply(tbl[i]);
        check_bht();

        // Collision on entry 4 (currently weakly taken), not-taken branch
        apply(mkv(1,1,0,0,3'b000,32'h10,32'h8,32'h0,1,0,0, 1,32'h14,0,0,0));
        apply(idle);
        check_bht();

        // Reset lands while a mispredicting branch is in EX
        @(negedge clk);
        ex_valid = 1; ex_is_branch = 1; ex_is_jal = 0; ex_is_jalr = 0;
        ex_funct3 = 3'b000; ex_pc = 32'h80; ex_imm = 32'h10;
        ex_pred_taken = 0; BEQ = 1; BLT = 0;
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("inrst_redirect_valid", 32'(redirect_valid), 32'h0);
        @(negedge clk);
        ex_valid = 0;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        chk("post_rst_redirect_valid", 32'(redirect_valid), 32'h0);
        chk("post_rst_flush", 32'(flush), 32'h0);
        chk("post_rst_illegal_br", 32'(illegal_br), 32'h0);
        chk("post_rst_branch_count", 32'(branch_count), 32'h0);
        chk("post_rst_mispredict_count", 32'(mispredict_count), 32'h0);
        check_bht();
        apply(mkv(1,1,0,0,3'b000,32'h80,32'h10,32'h0,0,1,0, 1,32'h90,0,0,1));
        apply(idle);
        check_bht();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
